// File: rtl/rom_reader_defs.sv
// rom_reader_defs: chip widths, default op codes and FSM encodings for the PROM reader
package rom_reader_defs;
  localparam int IP3604_DATA_WIDTH = 8;
  localparam int IP3604_ADDRESS_WIDTH = 9;
  localparam int IP3601_DATA_WIDTH = 4;
  localparam int IP3601_ADDRESS_WIDTH = 8;
  localparam logic [3:0] OP_READ_DEFAULT = 4'b1100;
  localparam logic [3:0] OP_IDLE_DEFAULT = 4'b1111;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SETTLE = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_PRESENT = 3'd3;
  localparam state_t ST_DONE = 3'd4;
endpackage

// File: rtl/rom_settle_timer.sv
// rom_settle_timer: loadable 8-bit down-counter, expired while the count is zero
module rom_settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] load_value,
  output logic       expired
);
  logic [7:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (enable && count != 8'd0) count <= count - 8'd1;
  assign expired = count == 8'd0;
endmodule

// File: rtl/rom_scan_controller.sv
// rom_scan_controller: steps a bipolar PROM through an address range and streams {address, data}
module rom_scan_controller
  import rom_reader_defs::*;
#(
  parameter int         DATA_WIDTH    = IP3604_DATA_WIDTH,
  parameter int         ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] OP_READ       = OP_READ_DEFAULT,
  parameter logic [3:0] OP_IDLE       = OP_IDLE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     single,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH-1:0] end_address,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address,
  output logic [3:0]               chip_operation,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  state_t state, nxt;
  logic [ADDRESS_WIDTH-1:0] end_q;
  logic single_q, expired, launch, advance, last;
  assign last = single_q || chip_address == end_q;
  always_comb
    nxt = (state != ST_IDLE && abort) ? ST_IDLE :
          state == ST_IDLE    ? ((start && !abort) ? ST_SETTLE : ST_IDLE) :
          state == ST_SETTLE  ? (expired ? ST_CAPTURE : ST_SETTLE) :
          state == ST_CAPTURE ? ST_PRESENT :
          state == ST_PRESENT ? (!(out_valid && out_ready) ? ST_PRESENT : last ? ST_DONE : ST_SETTLE) :
          ST_IDLE;
  assign launch  = state == ST_IDLE && nxt == ST_SETTLE;
  assign advance = state == ST_PRESENT && nxt == ST_SETTLE;
  rom_settle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (launch || advance),
    .enable     (state == ST_SETTLE),
    .load_value (SETTLE_LOAD),
    .expired    (expired)
  );
  // outputs are registered from the next state so they line up with the state change
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= ST_IDLE;
      chip_address   <= '0;
      chip_operation <= OP_IDLE;
      out_data       <= '0;
      out_address    <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      end_q          <= '0;
      single_q       <= 1'b0;
    end else begin
      state          <= nxt;
      busy           <= nxt != ST_IDLE;
      out_valid      <= nxt == ST_PRESENT;
      done           <= nxt == ST_DONE;
      chip_operation <= (nxt == ST_IDLE || nxt == ST_DONE) ? OP_IDLE : OP_READ;
      if (launch) begin
        chip_address <= start_address;
        end_q        <= end_address;
        single_q     <= single;
      end else if (advance) chip_address <= chip_address + ADDRESS_WIDTH'(1);
      if (state == ST_CAPTURE) begin
        out_data    <= chip_data_in;
        out_address <= chip_address;
      end
    end
endmodule

// File: tb/tb_rom_scan_controller.sv
// tb_rom_scan_controller: directed scans with a queued scoreboard checked by a separate monitor
module tb_rom_scan_controller;
  logic clk = 0, reset = 1, start = 0, single = 0, abort = 0, out_ready = 1, bp_mode = 0;
  logic [8:0] start_address = 0, end_address = 0, chip_address, out_address;
  logic [7:0] chip_data_in, out_data;
  logic [3:0] chip_operation;
  logic out_valid, busy, done;
  logic start4 = 0;
  logic [7:0] sa4 = 0, ea4 = 0, chip_address4, out_address4, exp4 = 0;
  logic [3:0] chip_data4, out_data4, chip_operation4;
  logic out_valid4, busy4, done4;
  int checks = 0, errors = 0, done_cnt = 0, words4 = 0;
  logic [16:0] sbq[$];
  logic [16:0] mexp, held_val;
  logic held = 0;
  always #5 clk = ~clk;
  assign chip_data_in = chip_address[7:0] ^ 8'hA5;
  assign chip_data4 = chip_address4[3:0] ^ 4'h5;
  rom_scan_controller dut (
    .clk(clk), .reset(reset), .start(start), .single(single), .abort(abort),
    .start_address(start_address), .end_address(end_address), .chip_data_in(chip_data_in),
    .chip_address(chip_address), .chip_operation(chip_operation), .out_data(out_data),
    .out_address(out_address), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );
  rom_scan_controller #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .single(1'b0), .abort(1'b0),
    .start_address(sa4), .end_address(ea4), .chip_data_in(chip_data4),
    .chip_address(chip_address4), .chip_operation(chip_operation4), .out_data(out_data4),
    .out_address(out_address4), .out_valid(out_valid4), .out_ready(1'b1), .busy(busy4), .done(done4)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_scan(input logic [8:0] sa, input logic [8:0] ea, input logic sg);
    logic [8:0] a;
    a = sa;
    forever begin
      sbq.push_back({a, a[7:0] ^ 8'hA5});
      if (sg || a == ea) break;
      a++;
    end
    start = 1; start_address = sa; end_address = ea; single = sg;
    tick();
    start = 0; start_address = 9'h155; end_address = ~ea; single = ~sg;
  endtask
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
    tick();
    chk("done_width", done, 0);
    chk("busy_after_done", busy, 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end
  always @(negedge clk) if (!reset) begin
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: got %h expected no word", {out_address, out_data});
      end else begin
        mexp = sbq.pop_front();
        chk("sb_word", {out_address, out_data}, mexp);
      end
    end
    if (held && out_valid) chk("stall_stable", {out_address, out_data}, held_val);
    held = out_valid && !out_ready;
    held_val = {out_address, out_data};
    if (done) done_cnt++;
    if (out_valid4) begin
      chk("w4_word", {out_address4, out_data4}, {exp4, exp4[3:0] ^ 4'h5});
      exp4++;
      words4++;
    end
  end
  initial begin
    int n, dc, pc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", chip_address, 0);
    chk("rst_op", chip_operation, 4'hF);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", {out_address, out_data}, 0);
    reset = 0;
    tick();
    dc = done_cnt;
    start_scan(9'h0AB, 9'h000, 1);
    chk("single_busy", busy, 1);
    chk("single_op", chip_operation, 4'hC);
    chk("single_addr", chip_address, 9'h0AB);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("single_latency", n, 5);
    wait_done(50, n);
    chk("single_done_lat", n, 1);
    chk("single_done_cnt", done_cnt, dc + 1);
    chk("single_sb_empty", sbq.size(), 0);
    dc = done_cnt;
    start_scan(9'h000, 9'h1FF, 0);
    wait_done(4000, n);
    chk("dump_cycles", n, 512 * 6);
    chk("dump_done_cnt", done_cnt, dc + 1);
    chk("dump_sb_empty", sbq.size(), 0);
    chk("dump_idle_op", chip_operation, 4'hF);
    start_scan(9'h1FE, 9'h001, 0);
    tick();
    start = 1; start_address = 9'h077;
    tick();
    start = 0;
    chk("busy_start_ignored", chip_address, 9'h1FE);
    wait_done(200, n);
    chk("wrap_sb_empty", sbq.size(), 0);
    bp_mode = 1;
    start_scan(9'h010, 9'h01F, 0);
    wait_done(3000, n);
    bp_mode = 0;
    chk("bp_sb_empty", sbq.size(), 0);
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk("abort_beats_start", busy, 0);
    dc = done_cnt;
    start_scan(9'h020, 9'h02F, 0);
    pc = 0; n = 0;
    while (pc < 3 && n < 100) begin
      tick(); n++;
      if (out_valid) pc++;
    end
    chk("abort_reach_third", pc, 3);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_op", chip_operation, 4'hF);
    repeat (4) tick();
    chk("abort_no_done", done_cnt, dc);
    chk("abort_consumed", sbq.size(), 13);
    sbq.delete();
    start_scan(9'h055, 9'h000, 1);
    wait_done(50, n);
    chk("restart_done_cnt", done_cnt, dc + 1);
    chk("restart_sb_empty", sbq.size(), 0);
    sa4 = 8'h00; ea4 = 8'hFF; start4 = 1;
    tick();
    start4 = 0;
    n = 0;
    while (!done4 && n < 2000) begin tick(); n++; end
    chk("d4_done", done4, 1);
    chk("d4_cycles", n, 256 * 6);
    chk("d4_words", words4, 256);
    dc = done_cnt;
    start_scan(9'h100, 9'h1FF, 0);
    tick();
    #2 reset = 1;
    #1;
    chk("arst_addr", chip_address, 0);
    chk("arst_op", chip_operation, 4'hF);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_data", {out_address, out_data}, 0);
    sbq.delete();
    held = 0;
    tick(); tick();
    reset = 0;
    repeat (3) tick();
    chk("arst_stays_idle", busy, 0);
    chk("arst_no_done", done_cnt, dc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
